// File: rtl/cla_pipe_acc.sv
// cla_pipe_acc: two-stage pipelined carry-lookahead adder/accumulator.
// S1 registers per-bit p/g and per-group Gm/Pm; S2 resolves group and
// in-group carries and registers sum/cout/ovf. Valid/ready on both sides.
// Optional build macro CLA_PIPE_ACC_SAT_EN saturates the result on overflow.
module cla_pipe_acc #(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / GRP;

  // S1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_acc_q, s1_acc_d;
  logic             s1_cin_q, s1_cin_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_gm_q, s1_gm_d;
  logic [NG-1:0]    s1_pm_q, s1_pm_d;

  // S2 / output state and accumulator
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Combinational intermediates
  logic [WIDTH-1:0] op_a, p_n, g_n;
  logic [NG-1:0]    gm_n, pm_n;
  logic [WIDTH-1:0] carries, sum_n;
  logic             carry_c, gg, pp, cout_n, ovf_n;
  logic             s2_load, accept;

  // An acc beat sitting in S1 blocks intake until its sum reaches acc_q.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s2_load) && !(s1_valid_q && s1_acc_q);
  assign accept   = in_valid && in_ready;

  // Operand select plus per-bit and per-group generate/propagate
  always_comb begin
    op_a = a;
    if (acc_mode) op_a = acc_clr ? '0 : acc_q;
    p_n  = op_a ^ b;
    g_n  = op_a & b;
    gm_n = '0;
    pm_n = '1;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GRP; j++) begin
        gm_n[k] = g_n[k*GRP+j] | (p_n[k*GRP+j] & gm_n[k]);
        pm_n[k] = pm_n[k] & p_n[k*GRP+j];
      end
    end
  end

  // S1 next state: load on accept, empty when S2 drains it
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_acc_d   = s1_acc_q;
    s1_cin_d   = s1_cin_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_gm_d    = s1_gm_q;
    s1_pm_d    = s1_pm_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_acc_d   = acc_mode;
      s1_cin_d   = cin;
      s1_p_d     = p_n;
      s1_g_d     = g_n;
      s1_gm_d    = gm_n;
      s1_pm_d    = pm_n;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Group carry chain, in-group lookahead from each group's carry-in
  always_comb begin
    carries = '0;
    carry_c = s1_cin_q;
    gg      = 1'b0;
    pp      = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        carries[k*GRP+j] = gg | (pp & carry_c);
        gg = s1_g_q[k*GRP+j] | (s1_p_q[k*GRP+j] & gg);
        pp = pp & s1_p_q[k*GRP+j];
      end
      carry_c = s1_gm_q[k] | (s1_pm_q[k] & carry_c);
    end
    cout_n = carry_c;
    ovf_n  = carries[WIDTH-1] ^ carry_c;
    sum_n  = s1_p_q ^ carries;
`ifdef CLA_PIPE_ACC_SAT_EN
    // On overflow both operands share a sign, so g[MSB] is that sign.
    if (ovf_n) sum_n = s1_g_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Output register and accumulator next state
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      sum_d       = sum_n;
      cout_d      = cout_n;
      ovf_d       = ovf_n;
      if (s1_acc_q) acc_d = sum_n;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // All pipeline state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_acc_q    <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_gm_q     <= '0;
      s1_pm_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_acc_q    <= s1_acc_d;
      s1_cin_q    <= s1_cin_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_gm_q     <= s1_gm_d;
      s1_pm_q     <= s1_pm_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_acc.sv
// tb_cla_pipe_acc: directed + random bench for cla_pipe_acc (WIDTH=16, GRP=4).
// Expected results come from integer addition in a queue-based scoreboard.
module tb_cla_pipe_acc;
  localparam int W = 16;
  typedef logic [W+1:0] res_t;  // {ovf, cout, sum}

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, acc_mode, acc_clr;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  int           tests = 0;
  int           fails = 0;
  res_t         exp_q[$];
  logic [W-1:0] acc_m;
  logic [W-1:0] last_sum;
  logic         pend_stall;
  res_t         held;
  logic         accepted;

  always #5 clk = ~clk;

  cla_pipe_acc #(.WIDTH(W), .GRP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s = t[W-1:0];
    o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef CLA_PIPE_ACC_SAT_EN
    if (o) s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {o, t[W], s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then move to just after the edge
  task automatic cyc();
    res_t         e, r;
    logic [W-1:0] av;
    #2;
    if (pend_stall) chk("stall_hold", 32'({out_valid, ovf, cout, sum}), 32'({1'b1, held}));
    pend_stall = 1'b0;
    if (out_valid && !out_ready) begin
      pend_stall = 1'b1;
      held = {ovf, cout, sum};
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("result", 32'({ovf, cout, sum}), 32'(e));
        last_sum = sum;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      av = acc_mode ? (acc_clr ? '0 : acc_m) : a;
      r  = model(av, b, cin);
      exp_q.push_back(r);
      if (acc_mode) acc_m = r[W-1:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic am, input logic ac);
    int n;
    a = av; b = bv; cin = ci; acc_mode = am; acc_clr = ac; in_valid = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!accepted && n < 50);
    if (!accepted) chk("send_timeout", 32'(accepted), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin cyc(); n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    acc_m = '0; last_sum = '0; pend_stall = 1'b0; held = '0; accepted = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));

    // basic add with latency check
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("lat_t1", 32'(out_valid), 32'(0));
    cyc();
    chk("lat_t2", 32'(out_valid), 32'(1));
    chk("basic_sum", 32'(sum), 32'h0100);
    chk("basic_cout", 32'(cout), 32'(0));
    chk("basic_ovf", 32'(ovf), 32'(0));
    drain();

    // full-width carry
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("fc_sum", 32'(sum), 32'h0000);
    chk("fc_cout", 32'(cout), 32'(1));
    chk("fc_ovf", 32'(ovf), 32'(0));
    drain();

    // signed overflow
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("ovf_flag", 32'(ovf), 32'(1));
    chk("ovf_cout", 32'(cout), 32'(0));
`ifdef CLA_PIPE_ACC_SAT_EN
    chk("ovf_sum", 32'(sum), 32'h7FFF);
`else
    chk("ovf_sum", 32'(sum), 32'h8000);
`endif
    drain();

    // backpressure: both stages fill, intake stalls, then all 4 emerge in order
    out_ready = 1'b0;
    send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    send(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; acc_mode = 1'b0; in_valid = 1'b1;
    chk("bp_full_ready", 32'(in_ready), 32'(0));
    repeat (3) begin
      cyc();
      chk("bp_held_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h8001, 1'b1, 1'b0, 1'b0);
    drain();
    chk("bp_last", 32'(last_sum), 32'(model(16'h8000, 16'h8001, 1'b1) & 18'h0FFFF));

    // accumulate chain with interlock
    send(16'hAAAA, 16'h0005, 1'b0, 1'b1, 1'b1);
    chk("acc1_ready", 32'(in_ready), 32'(0));
    drain();
    chk("acc1_sum", 32'(last_sum), 32'h0005);
    send(16'hAAAA, 16'h0007, 1'b0, 1'b1, 1'b0);
    chk("acc2_ready", 32'(in_ready), 32'(0));
    drain();
    chk("acc2_sum", 32'(last_sum), 32'h000C);
    send(16'hAAAA, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    chk("acc3_ready", 32'(in_ready), 32'(0));
    drain();
    chk("acc3_sum", 32'(last_sum), 32'h000A);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_ready", 32'(in_ready), 32'(0));
    exp_q.delete();
    pend_stall = 1'b0;
    acc_m = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_ov", 32'(out_valid), 32'(0));
    end
    send(16'hFFFF, 16'h0003, 1'b0, 1'b1, 1'b0);
    drain();
    chk("post_rst_acc", 32'(last_sum), 32'h0003);

    // random mixed traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      acc_mode  = ($urandom_range(0, 3) == 0);
      acc_clr   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
